multicycle_control_unit: RTL and testbench

- Sequential successor to the combinational single-cycle control unit of the 16-bit datapath.
- Moore FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Adds multi-cycle floating-point multiply (FPM), a program-requested stall, a sticky halt, and a memory-ready handshake.
- Drives the same control lines as before, plus PC/IR write enables and status.

---
 rtl/datapath_pkg.sv | 28 ++
 rtl/cycle_counter.sv | 31 +++
 rtl/multicycle_control_unit.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and constants for the 16-bit datapath control logic.
package datapath_pkg;

  // FSM state encodings; the 3-bit values are visible on the debug port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_STALL  = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // Opcodes
  localparam logic [3:0] TYPE_A = 4'b0000;
  localparam logic [3:0] LOAD   = 4'b1000;
  localparam logic [3:0] STORE  = 4'b1100;
  localparam logic [3:0] BRANCH = 4'b0100;
  localparam logic [3:0] STALL  = 4'b0111;
  localparam logic [3:0] JUMP   = 4'b1011;
  localparam logic [3:0] HALT   = 4'b1111;

  // Function code selecting the multi-cycle FP multiply
  localparam logic [3:0] FPM = 4'b0010;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with terminal-count flag, shared by FPM and STALL.
module cycle_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal at 1, and also at 0 so a zero load still exits after one cycle
  always_comb begin
    tc = (count == '0) || (count == CNT_W'(1));
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// FP-multiply latency, program stall, sticky halt and memory handshake.
module multicycle_control_unit
  import datapath_pkg::*;
#(
  parameter int unsigned OP_W         = 4,
  parameter int unsigned FN_W         = 4,
  parameter int unsigned FPM_CYCLES   = 4,
  parameter int unsigned STALL_CYCLES = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            RegDst,
  output logic            ALUOp1,
  output logic            ALUOp0,
  output logic            ALUSrc,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Jump,
  output logic            RegWrite,
  output logic            MemtoReg,
  output logic            FPC,
  output logic            pc_write,
  output logic            ir_write,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state
);

  localparam logic [CNT_W-1:0] FPM_LD   = CNT_W'(FPM_CYCLES);
  localparam logic [CNT_W-1:0] STALL_LD = CNT_W'((STALL_CYCLES == 0) ? 1 : STALL_CYCLES);

  state_t          st;
  logic [OP_W-1:0] op_q;
  logic [FN_W-1:0] fn_q;
  logic            is_fpm;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_tc;
  logic [CNT_W-1:0] cnt_val;

  assign state  = st;
  assign is_fpm = (op_q == TYPE_A) && (fn_q == FPM);

  // Counter control: load from the live opcode in DECODE, count down in FPM EXEC or STALL
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = FPM_LD;
    if (st == ST_DECODE) begin
      if (opcode == STALL) begin
        cnt_load = 1'b1;
        cnt_val  = STALL_LD;
      end else if ((opcode == TYPE_A) && (funct == FPM)) begin
        cnt_load = 1'b1;
      end
    end
    cnt_dec = ((st == ST_EXEC) && is_fpm) || (st == ST_STALL);
  end

  cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // State register with opcode/funct latch taken in DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= ST_IDLE;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      case (st)
        ST_IDLE:  st <= ST_FETCH;
        ST_FETCH: if (mem_ready) st <= ST_DECODE;
        ST_DECODE: begin
          op_q <= opcode;
          fn_q <= funct;
          case (opcode)
            TYPE_A, LOAD, STORE, BRANCH: st <= ST_EXEC;
            STALL:                       st <= ST_STALL;
            HALT:                        st <= ST_HALT;
            default:                     st <= ST_FETCH;
          endcase
        end
        ST_EXEC: begin
          case (op_q)
            TYPE_A:      if (!is_fpm || cnt_tc) st <= ST_WB;
            LOAD, STORE: st <= ST_MEM;
            default:     st <= ST_FETCH;
          endcase
        end
        ST_MEM: if (mem_ready) st <= (op_q == LOAD) ? ST_WB : ST_FETCH;
        ST_WB:    st <= ST_FETCH;
        ST_STALL: if (cnt_tc) st <= ST_FETCH;
        ST_HALT:  st <= ST_HALT;
        default:  st <= ST_IDLE;
      endcase
    end
  end

  // Output decode from current state, latched op/funct and handshake inputs
  always_comb begin
    RegDst   = 1'b0;
    ALUOp1   = 1'b0;
    ALUOp0   = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Jump     = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    FPC      = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (st)
      ST_FETCH: begin
        MemRead  = 1'b1;
        ir_write = 1'b1;
        pc_write = mem_ready;
      end
      ST_DECODE: begin
        case (opcode)
          JUMP: begin
            Jump     = 1'b1;
            pc_write = 1'b1;
          end
          TYPE_A, LOAD, STORE, BRANCH, STALL, HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      ST_EXEC: begin
        case (op_q)
          TYPE_A: begin
            ALUOp1 = 1'b1;
            FPC    = is_fpm;
          end
          LOAD, STORE: ALUSrc = 1'b1;
          BRANCH: begin
            Branch   = 1'b1;
            ALUOp0   = 1'b1;
            pc_write = zero;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        MemRead  = (op_q == LOAD);
        MemWrite = (op_q == STORE);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_q == TYPE_A);
        MemtoReg = (op_q == LOAD);
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite, Jump;
  logic       RegWrite, MemtoReg, FPC, pc_write, ir_write, halted, illegal;
  logic [2:0] state;
  logic [14:0] ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [14:0] C_REGDST = 15'h4000;
  localparam logic [14:0] C_ALUOP1 = 15'h2000;
  localparam logic [14:0] C_ALUOP0 = 15'h1000;
  localparam logic [14:0] C_ALUSRC = 15'h0800;
  localparam logic [14:0] C_BRANCH = 15'h0400;
  localparam logic [14:0] C_MRD    = 15'h0200;
  localparam logic [14:0] C_MWR    = 15'h0100;
  localparam logic [14:0] C_JUMP   = 15'h0080;
  localparam logic [14:0] C_RWR    = 15'h0040;
  localparam logic [14:0] C_M2R    = 15'h0020;
  localparam logic [14:0] C_FPC    = 15'h0010;
  localparam logic [14:0] C_PCW    = 15'h0008;
  localparam logic [14:0] C_IRW    = 15'h0004;
  localparam logic [14:0] C_HALT   = 15'h0002;
  localparam logic [14:0] C_ILL    = 15'h0001;
  localparam logic [14:0] C_FETCH  = C_MRD | C_IRW | C_PCW;

  multicycle_control_unit #(
    .OP_W(4), .FN_W(4), .FPM_CYCLES(4), .STALL_CYCLES(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .RegDst(RegDst), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0),
    .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .Jump(Jump), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .FPC(FPC),
    .pc_write(pc_write), .ir_write(ir_write), .halted(halted), .illegal(illegal),
    .state(state)
  );

  assign ctl = {RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite, Jump,
                RegWrite, MemtoReg, FPC, pc_write, ir_write, halted, illegal};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check state and controls of the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] c);
    #1;
    check({tag, ".state"}, {29'd0, state}, {29'd0, st});
    check({tag, ".ctl"}, {17'd0, ctl}, {17'd0, c});
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; opcode = 4'b0000; funct = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    cyc("rst", 3'd0, 15'h0);
    reset = 1'b0;
    cyc("idle", 3'd0, 15'h0);

    // Type A, funct 0001
    opcode = 4'b0000; funct = 4'b0001;
    cyc("ta.f", 3'd1, C_FETCH);
    cyc("ta.d", 3'd2, 15'h0);
    cyc("ta.e", 3'd3, C_ALUOP1);
    cyc("ta.w", 3'd5, C_RWR | C_REGDST);

    // FPM; live opcode scrambled after DECODE must not matter
    opcode = 4'b0000; funct = 4'b0010;
    cyc("fpm.f", 3'd1, C_FETCH);
    cyc("fpm.d", 3'd2, 15'h0);
    opcode = 4'b1011; funct = 4'b0000;
    for (int i = 0; i < 4; i++) cyc($sformatf("fpm.e%0d", i), 3'd3, C_ALUOP1 | C_FPC);
    cyc("fpm.w", 3'd5, C_RWR | C_REGDST);

    // LOAD with memory wait
    opcode = 4'b1000;
    cyc("ld.f", 3'd1, C_FETCH);
    cyc("ld.d", 3'd2, 15'h0);
    cyc("ld.e", 3'd3, C_ALUSRC);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("ld.mw%0d", i), 3'd4, C_MRD);
    mem_ready = 1'b1;
    cyc("ld.m", 3'd4, C_MRD);
    cyc("ld.w", 3'd5, C_RWR | C_M2R);

    // STORE, with a FETCH wait first
    opcode = 4'b1100; mem_ready = 1'b0;
    cyc("st.fw", 3'd1, C_MRD | C_IRW);
    mem_ready = 1'b1;
    cyc("st.f", 3'd1, C_FETCH);
    cyc("st.d", 3'd2, 15'h0);
    cyc("st.e", 3'd3, C_ALUSRC);
    cyc("st.m", 3'd4, C_MWR);

    // BRANCH taken then not taken
    opcode = 4'b0100; zero = 1'b1;
    cyc("bt.f", 3'd1, C_FETCH);
    cyc("bt.d", 3'd2, 15'h0);
    cyc("bt.e", 3'd3, C_BRANCH | C_ALUOP0 | C_PCW);
    zero = 1'b0;
    cyc("bn.f", 3'd1, C_FETCH);
    cyc("bn.d", 3'd2, 15'h0);
    cyc("bn.e", 3'd3, C_BRANCH | C_ALUOP0);

    // JUMP
    opcode = 4'b1011;
    cyc("j.f", 3'd1, C_FETCH);
    cyc("j.d", 3'd2, C_JUMP | C_PCW);

    // STALL
    opcode = 4'b0111;
    cyc("stl.f", 3'd1, C_FETCH);
    cyc("stl.d", 3'd2, 15'h0);
    for (int i = 0; i < 3; i++) cyc($sformatf("stl.s%0d", i), 3'd6, 15'h0);

    // Undefined opcode
    opcode = 4'b0011;
    cyc("il.f", 3'd1, C_FETCH);
    cyc("il.d", 3'd2, C_ILL);
    opcode = 4'b1111;
    cyc("il.f2", 3'd1, C_FETCH);

    // HALT is sticky regardless of inputs
    cyc("h.d", 3'd2, 15'h0);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      cyc($sformatf("h.%0d", i), 3'd7, C_HALT);
    end

    // Second run: reset in the middle of FPM EXEC
    reset = 1'b1; mem_ready = 1'b1;
    cyc("r2.rst", 3'd0, 15'h0);
    reset = 1'b0;
    cyc("r2.idle", 3'd0, 15'h0);
    opcode = 4'b0000; funct = 4'b0010;
    cyc("r2.f", 3'd1, C_FETCH);
    cyc("r2.d", 3'd2, 15'h0);
    cyc("r2.e0", 3'd3, C_ALUOP1 | C_FPC);
    #1;
    check("r2.pre", {17'd0, ctl}, {17'd0, C_ALUOP1 | C_FPC});
    reset = 1'b1;
    #1;
    check("r2.async.state", {29'd0, state}, 32'd0);
    check("r2.async.ctl", {17'd0, ctl}, 32'd0);
    @(posedge clk);
    #2;
    cyc("r2.hold", 3'd0, 15'h0);
    reset = 1'b0;
    cyc("r2.idle2", 3'd0, 15'h0);
    cyc("r2.f2", 3'd1, C_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
